// File: rtl/posit_pkg.sv
// Shared widths, special posit encodings and the stage-1 record for the
// posit round/encode output stage.
package posit_pkg;

  localparam int N  = 16;
  localparam int ES = 1;
  localparam int SW = 7;

  localparam int MAX_SCALE = (N - 2) << ES;

  localparam logic [N-1:0] POSIT_MAXPOS = 16'h7FFF;
  localparam logic [N-1:0] POSIT_MINPOS = 16'h0001;
  localparam logic [N-1:0] POSIT_NAR    = 16'h8000;
  localparam logic [N-1:0] POSIT_ZERO   = 16'h0000;

  // Stage-1 register contents: truncated magnitude plus everything rounding needs.
  typedef struct packed {
    logic         sign;
    logic [N-2:0] kept;
    logic         guard;
    logic         sticky;
    logic         sat_max;
    logic         sat_min;
    logic         zero;
    logic         nar;
  } s1_t;

  // Number of regime bits, terminator included, for regime value k.
  function automatic int regime_len(input int k);
    return (k >= 0) ? k + 2 : 1 - k;
  endfunction

endpackage

// File: rtl/posit_round_encode_if.sv
// Operand/result handshake bundle between the normalizer and the posit
// round/encode stage.
interface posit_round_encode_if;
  import posit_pkg::*;

  logic          i_valid;
  logic          o_ready;
  logic          i_sign;
  logic [SW-1:0] i_scale;
  logic [N:0]    i_frac;
  logic          i_sticky;
  logic          i_zero;
  logic          i_nar;
  logic          o_valid;
  logic          i_ready;
  logic [N-1:0]  o_posit;

  modport master (
    output i_valid, i_sign, i_scale, i_frac, i_sticky, i_zero, i_nar, i_ready,
    input  o_ready, o_valid, o_posit
  );

  modport slave (
    input  i_valid, i_sign, i_scale, i_frac, i_sticky, i_zero, i_nar, i_ready,
    output o_ready, o_valid, o_posit
  );

endinterface

// File: rtl/posit_regime_shifter.sv
// Builds the regime/exponent/fraction string and right-aligns it by the
// regime length, returning the kept magnitude bits, guard and sticky.
module posit_regime_shifter
  import posit_pkg::*;
(
  input  logic [SW-1:0] scale,
  input  logic [N-1:0]  frac,
  output logic [N-2:0]  kept,
  output logic          guard,
  output logic          sticky
);

  // Wider than 2N so the longest in-range regime still keeps its whole tail.
  localparam int FW      = 2 * N + 8;
  localparam int SH_BITS = 4;

  logic signed [SW-1:0] k;
  logic                 k_neg;
  logic                 fill;
  logic [SH_BITS-1:0]   amt;
  logic [FW-1:0]        stage [0:SH_BITS];

  assign k     = $signed(scale) >>> ES;
  assign k_neg = k[SW-1];
  assign fill  = ~k_neg;

  // Out-of-range scales saturate downstream, so truncating amt is harmless.
  assign amt = SH_BITS'(k_neg ? regime_len(int'(k)) - 1 : regime_len(int'(k)) - 2);

  // Positive k: "10" shifted in with ones; negative k: "1" shifted in with zeros.
  assign stage[0] = k_neg ? {1'b1, scale[ES-1:0], frac, {(FW - 1 - ES - N){1'b0}}}
                          : {2'b10, scale[ES-1:0], frac, {(FW - 2 - ES - N){1'b0}}};

  genvar gi;
  generate
    for (gi = 0; gi < SH_BITS; gi++) begin : g_shift
      assign stage[gi+1] = amt[gi] ? {{(2**gi){fill}}, stage[gi][FW-1:2**gi]}
                                   : stage[gi];
    end
  endgenerate

  assign kept   = stage[SH_BITS][FW-1 -: N-1];
  assign guard  = stage[SH_BITS][FW-N];
  assign sticky = |stage[SH_BITS][FW-N-1:0];

endmodule

// File: rtl/posit_round_encode.sv
// Two-stage elastic output stage: encode regime/exponent/fraction, then
// round to nearest even, saturate, negate and emit the posit.
module posit_round_encode
  import posit_pkg::*;
(
  input logic                 i_clk,
  input logic                 i_rst_n,
  posit_round_encode_if.slave bus
);

  logic          s1_valid_reg;
  s1_t           s1_reg;
  s1_t           s1_next;
  logic          s2_valid_reg;
  logic [N-1:0]  s2_posit_reg;
  logic [N-1:0]  s2_posit_next;

  logic          s1_adv;
  logic          in_ready;

  logic [N-2:0]  sh_kept;
  logic          sh_guard;
  logic          sh_sticky;

  logic          round_up;
  logic [N-1:0]  mag;

  // The hidden one is implied by the normalizer and carries no information here.
  logic          unused_hidden;
  assign unused_hidden = bus.i_frac[N];

  assign s1_adv   = !s2_valid_reg || bus.i_ready;
  assign in_ready = !s1_valid_reg || s1_adv;

  assign bus.o_ready = in_ready;
  assign bus.o_valid = s2_valid_reg;
  assign bus.o_posit = s2_posit_reg;

  posit_regime_shifter u_shifter (
    .scale  (bus.i_scale),
    .frac   (bus.i_frac[N-1:0]),
    .kept   (sh_kept),
    .guard  (sh_guard),
    .sticky (sh_sticky)
  );

  always_comb begin
    s1_next         = '0;
    s1_next.sign    = bus.i_sign;
    s1_next.kept    = sh_kept;
    s1_next.guard   = sh_guard;
    s1_next.sticky  = sh_sticky | bus.i_sticky;
    s1_next.sat_max = int'($signed(bus.i_scale)) > MAX_SCALE;
    s1_next.sat_min = int'($signed(bus.i_scale)) < -MAX_SCALE;
    s1_next.nar     = bus.i_nar;
    s1_next.zero    = bus.i_zero & ~bus.i_nar;
  end

  // Rounding never carries into NaR and never collapses a nonzero value to zero.
  always_comb begin
    round_up = s1_reg.guard && (s1_reg.kept[0] || s1_reg.sticky) &&
               (s1_reg.kept != POSIT_MAXPOS[N-2:0]);
    mag = {1'b0, s1_reg.kept} + N'(round_up);
    if (mag == POSIT_ZERO) begin
      mag = POSIT_MINPOS;
    end
    if (s1_reg.sat_max) begin
      mag = POSIT_MAXPOS;
    end else if (s1_reg.sat_min) begin
      mag = POSIT_MINPOS;
    end
    s2_posit_next = s1_reg.sign ? -mag : mag;
    if (s1_reg.nar) begin
      s2_posit_next = POSIT_NAR;
    end else if (s1_reg.zero) begin
      s2_posit_next = POSIT_ZERO;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
      s2_valid_reg <= 1'b0;
      s2_posit_reg <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_reg <= bus.i_valid;
        if (bus.i_valid) begin
          s1_reg <= s1_next;
        end
      end
      if (s1_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_posit_reg <= s2_posit_next;
        end
      end
    end
  end

endmodule
